regfile_mp: RTL and testbench

Parametrised multi-port integer register file for the core's decode/writeback boundary, successor to the single-write-port file. It provides `NUM_RD` combinational read ports and `NUM_WR` synchronous write ports, with same-cycle write-to-read bypass. A per-register busy scoreboard is set at issue and cleared at writeback, so decode can stall on in-flight destinations. Register 0 always reads zero and is never busy.

---
 rtl/regfile_mp_pkg.sv | 29 ++
 rtl/regfile_mp_bypass.sv | 52 +++++
 rtl/regfile_mp.sv | 115 +++++++++++
 tb/tb_regfile_mp.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_mp_pkg.sv
// ============================================================================
//  Module   : CorePack (package)
//  Purpose  : Shared core types for the register file and its neighbours:
//             the data word, the register index, a write-port bundle, and
//             default port counts for the multi-port register file.
//  Revision : 1.0 - initial multi-port register file support
// ============================================================================
`default_nettype none

package CorePack;

    localparam int XLEN      = 64;
    localparam int NUM_ARCH  = 32;
    localparam int RF_NUM_RD = 2;
    localparam int RF_NUM_WR = 2;

    typedef logic [XLEN-1:0]             data_t;
    typedef logic [$clog2(NUM_ARCH)-1:0] reg_ind_t;

    // One write port as seen from writeback.
    typedef struct packed {
        logic     we;
        reg_ind_t addr;
        data_t    data;
    } rf_wr_t;

endpackage : CorePack

`default_nettype wire

// File: rtl/regfile_mp_bypass.sv
// ============================================================================
//  Module   : regfile_bypass
//  Purpose  : Read-side forwarding for one read port. Selects, in priority
//             order, zero for register 0, the highest-index enabled write
//             port whose address matches, or the stored array value.
//  Ports    : read_addr   - source index of this read port
//             stored_data - array contents at read_addr
//             we          - per-write-port enable
//             write_addr  - per-write-port destination index
//             write_data  - per-write-port data
//             read_data   - forwarded / stored result
//             write_hit   - an enabled write targets read_addr this cycle
//  Revision : 1.0 - initial version
// ============================================================================
`default_nettype none

module regfile_bypass
    import CorePack::*;
#(
    parameter int DATA_WIDTH = $bits(data_t),
    parameter int AW         = $bits(reg_ind_t),
    parameter int NUM_WR     = RF_NUM_WR
) (
    input  logic [AW-1:0]                        read_addr,
    input  logic [DATA_WIDTH-1:0]                stored_data,
    input  logic [NUM_WR-1:0]                    we,
    input  logic [NUM_WR-1:0][AW-1:0]            write_addr,
    input  logic [NUM_WR-1:0][DATA_WIDTH-1:0]    write_data,
    output logic [DATA_WIDTH-1:0]                read_data,
    output logic                                 write_hit
);

    always_comb begin
        read_data = stored_data;
        write_hit = 1'b0;
        if (read_addr == '0) begin
            read_data = '0;
        end else begin
            // Ascending scan: the last match (highest port index) wins,
            // matching the write-conflict rule of the array.
            for (int k = 0; k < NUM_WR; k++) begin
                if (we[k] && (write_addr[k] == read_addr)) begin
                    read_data = write_data[k];
                    write_hit = 1'b1;
                end
            end
        end
    end

endmodule : regfile_bypass

`default_nettype wire

// File: rtl/regfile_mp.sv
// ============================================================================
//  Module   : regfile_mp
//  Purpose  : Multi-port integer register file with same-cycle write-to-read
//             bypass and a per-register busy scoreboard. Register 0 reads
//             zero, is never stored and is never busy.
//  Ports    : clk, rst              - clock, synchronous active-high reset
//             we/write_addr/data    - NUM_WR synchronous write ports
//             read_addr/read_data   - NUM_RD combinational read ports
//             read_busy             - source pending and not written now
//             busy_set/busy_addr    - issue-side destination claim
//             busy_vec              - raw scoreboard, bit 0 tied low
//  Revision : 1.0 - successor to the single-write-port register file
// ============================================================================
`default_nettype none

module regfile_mp
    import CorePack::*;
#(
    parameter  int DATA_WIDTH = $bits(data_t),
    parameter  int NUM_REGS   = NUM_ARCH,
    parameter  int NUM_RD     = RF_NUM_RD,
    parameter  int NUM_WR     = RF_NUM_WR,
    localparam int AW         = $clog2(NUM_REGS)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_WR-1:0]                    we,
    input  logic [NUM_WR-1:0][AW-1:0]            write_addr,
    input  logic [NUM_WR-1:0][DATA_WIDTH-1:0]    write_data,
    input  logic [NUM_RD-1:0][AW-1:0]            read_addr,
    output logic [NUM_RD-1:0][DATA_WIDTH-1:0]    read_data,
    output logic [NUM_RD-1:0]                    read_busy,
    input  logic                                 busy_set,
    input  logic [AW-1:0]                        busy_addr,
    output logic [NUM_REGS-1:0]                  busy_vec
);

    // Array view for the read muxes; entry 0 is a hard zero, not storage.
    logic [DATA_WIDTH-1:0] w_stored [NUM_REGS];

    assign w_stored[0] = '0;
    assign busy_vec[0] = 1'b0;

    // ------------------------------------------------------------------
    // Storage and scoreboard, one slice per architectural register 1..N-1
    // ------------------------------------------------------------------
    for (genvar i = 1; i < NUM_REGS; i++) begin : g_reg
        logic [DATA_WIDTH-1:0] r_data;
        logic                  r_busy;
        logic                  w_wr_hit;
        logic [DATA_WIDTH-1:0] w_wr_data;

        // Highest-index matching port wins a same-register conflict.
        always_comb begin
            w_wr_hit  = 1'b0;
            w_wr_data = r_data;
            for (int k = 0; k < NUM_WR; k++) begin
                if (we[k] && (write_addr[k] == AW'(i))) begin
                    w_wr_hit  = 1'b1;
                    w_wr_data = write_data[k];
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_data <= '0;
            end else if (w_wr_hit) begin
                r_data <= w_wr_data;
            end
        end

        // Set beats clear: the newly issued instruction owns the register
        // even if an older producer writes back on the same edge.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_busy <= 1'b0;
            end else if (busy_set && (busy_addr == AW'(i))) begin
                r_busy <= 1'b1;
            end else if (w_wr_hit) begin
                r_busy <= 1'b0;
            end
        end

        assign w_stored[i] = r_data;
        assign busy_vec[i] = r_busy;
    end

    // ------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------
    for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
        logic w_hit;

        regfile_bypass #(
            .DATA_WIDTH (DATA_WIDTH),
            .AW         (AW),
            .NUM_WR     (NUM_WR)
        ) u_bypass (
            .read_addr   (read_addr[r]),
            .stored_data (w_stored[read_addr[r]]),
            .we          (we),
            .write_addr  (write_addr),
            .write_data  (write_data),
            .read_data   (read_data[r]),
            .write_hit   (w_hit)
        );

        // busy_vec[0] is tied low, so address 0 is never reported busy.
        assign read_busy[r] = busy_vec[read_addr[r]] & ~w_hit;
    end

endmodule : regfile_mp

`default_nettype wire

// File: tb/tb_regfile_mp.sv
// ============================================================================
//  Module   : tb_regfile_mp
//  Purpose  : Directed self-checking bench for regfile_mp (default sizes).
//  Revision : 1.0 - initial version
// ============================================================================
`default_nettype none

module tb_regfile_mp;

    localparam int DW = 64;
    localparam int NR = 32;
    localparam int RD = 2;
    localparam int WR = 2;
    localparam int AW = 5;

    logic                      clk;
    logic                      rst;
    logic [WR-1:0]             we;
    logic [WR-1:0][AW-1:0]     write_addr;
    logic [WR-1:0][DW-1:0]     write_data;
    logic [RD-1:0][AW-1:0]     read_addr;
    logic [RD-1:0][DW-1:0]     read_data;
    logic [RD-1:0]             read_busy;
    logic                      busy_set;
    logic [AW-1:0]             busy_addr;
    logic [NR-1:0]             busy_vec;

    int n_checks = 0;
    int n_fail   = 0;

    regfile_mp #(
        .DATA_WIDTH (DW),
        .NUM_REGS   (NR),
        .NUM_RD     (RD),
        .NUM_WR     (WR)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .we         (we),
        .write_addr (write_addr),
        .write_data (write_data),
        .read_addr  (read_addr),
        .read_data  (read_data),
        .read_busy  (read_busy),
        .busy_set   (busy_set),
        .busy_addr  (busy_addr),
        .busy_vec   (busy_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; inputs change 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we         = '0;
        write_addr = '0;
        write_data = '0;
        busy_set   = 1'b0;
        busy_addr  = '0;
    endtask

    task automatic test_reset();
        read_addr[0] = 5'd1;
        read_addr[1] = 5'd31;
        #1;
        n_checks++;
        if (read_data[0] !== 64'd0) begin
            n_fail++; $display("FAIL reset_x1: got %h want 0", read_data[0]);
        end
        n_checks++;
        if (read_data[1] !== 64'd0) begin
            n_fail++; $display("FAIL reset_x31: got %h want 0", read_data[1]);
        end
        n_checks++;
        if (busy_vec !== 32'd0 || read_busy !== 2'b00) begin
            n_fail++; $display("FAIL reset_busy: vec %h rb %b want 0", busy_vec, read_busy);
        end
        read_addr[0] = 5'd0;
        #1;
        n_checks++;
        if (read_data[0] !== 64'd0) begin
            n_fail++; $display("FAIL reset_x0: got %h want 0", read_data[0]);
        end
    endtask

    task automatic test_bypass();
        we[0] = 1'b1; write_addr[0] = 5'd5; write_data[0] = 64'h1234;
        read_addr[0] = 5'd5;
        #1;
        n_checks++;
        if (read_data[0] !== 64'h1234) begin
            n_fail++; $display("FAIL bypass_same_cycle: got %h want 1234", read_data[0]);
        end
        tick();
        idle();
        read_addr[1] = 5'd5;
        #1;
        n_checks++;
        if (read_data[0] !== 64'h1234 || read_data[1] !== 64'h1234) begin
            n_fail++; $display("FAIL bypass_stored: got %h/%h want 1234", read_data[0], read_data[1]);
        end
    endtask

    task automatic test_conflict();
        we = 2'b11;
        write_addr[0] = 5'd7; write_data[0] = 64'hAA;
        write_addr[1] = 5'd7; write_data[1] = 64'hBB;
        read_addr[0] = 5'd7; read_addr[1] = 5'd7;
        #1;
        n_checks++;
        if (read_data[0] !== 64'hBB || read_data[1] !== 64'hBB) begin
            n_fail++; $display("FAIL conflict_bypass: got %h/%h want bb", read_data[0], read_data[1]);
        end
        tick();
        idle();
        #1;
        n_checks++;
        if (read_data[0] !== 64'hBB) begin
            n_fail++; $display("FAIL conflict_stored: got %h want bb", read_data[0]);
        end
        // Port 0 alone must still write when port 1 targets elsewhere.
        we = 2'b11;
        write_addr[0] = 5'd8;  write_data[0] = 64'hC0FFEE;
        write_addr[1] = 5'd10; write_data[1] = 64'hD00D;
        tick();
        idle();
        read_addr[0] = 5'd8; read_addr[1] = 5'd10;
        #1;
        n_checks++;
        if (read_data[0] !== 64'hC0FFEE || read_data[1] !== 64'hD00D) begin
            n_fail++; $display("FAIL dual_write: got %h/%h want c0ffee/d00d", read_data[0], read_data[1]);
        end
    endtask

    task automatic test_x0();
        we[0] = 1'b1; write_addr[0] = 5'd0; write_data[0] = 64'hFFFF;
        read_addr[0] = 5'd0;
        #1;
        n_checks++;
        if (read_data[0] !== 64'd0) begin
            n_fail++; $display("FAIL x0_bypass: got %h want 0", read_data[0]);
        end
        tick();
        idle();
        busy_set = 1'b1; busy_addr = 5'd0;
        tick();
        idle();
        #1;
        n_checks++;
        if (read_data[0] !== 64'd0) begin
            n_fail++; $display("FAIL x0_stored: got %h want 0", read_data[0]);
        end
        n_checks++;
        if (busy_vec !== 32'd0 || read_busy[0] !== 1'b0) begin
            n_fail++; $display("FAIL x0_busy: vec %h rb %b want 0", busy_vec, read_busy[0]);
        end
    endtask

    task automatic test_busy();
        busy_set = 1'b1; busy_addr = 5'd9;
        read_addr[0] = 5'd9;
        #1;
        n_checks++;
        if (read_busy[0] !== 1'b0) begin
            n_fail++; $display("FAIL busy_latency: got %b want 0", read_busy[0]);
        end
        tick();
        idle();
        #1;
        n_checks++;
        if (read_busy[0] !== 1'b1 || busy_vec !== 32'h0000_0200) begin
            n_fail++; $display("FAIL busy_set: rb %b vec %h want 1/00000200", read_busy[0], busy_vec);
        end
        we[1] = 1'b1; write_addr[1] = 5'd9; write_data[1] = 64'h42;
        #1;
        n_checks++;
        if (read_busy[0] !== 1'b0 || read_data[0] !== 64'h42) begin
            n_fail++; $display("FAIL busy_wb_bypass: rb %b data %h want 0/42", read_busy[0], read_data[0]);
        end
        n_checks++;
        if (busy_vec !== 32'h0000_0200) begin
            n_fail++; $display("FAIL busy_wb_raw: got %h want 00000200", busy_vec);
        end
        tick();
        idle();
        #1;
        n_checks++;
        if (busy_vec !== 32'd0 || read_busy[0] !== 1'b0) begin
            n_fail++; $display("FAIL busy_cleared: vec %h rb %b want 0", busy_vec, read_busy[0]);
        end
    endtask

    task automatic test_set_clear_reset();
        busy_set = 1'b1; busy_addr = 5'd3;
        we[0] = 1'b1; write_addr[0] = 5'd3; write_data[0] = 64'h10;
        tick();
        idle();
        read_addr[0] = 5'd3;
        #1;
        n_checks++;
        if (busy_vec !== 32'h0000_0008 || read_busy[0] !== 1'b1) begin
            n_fail++; $display("FAIL set_wins: vec %h rb %b want 00000008/1", busy_vec, read_busy[0]);
        end
        n_checks++;
        if (read_data[0] !== 64'h10) begin
            n_fail++; $display("FAIL set_wins_data: got %h want 10", read_data[0]);
        end
        // Reset edge with a write and a claim pending: bypass is visible,
        // nothing is stored, nothing is claimed.
        rst = 1'b1;
        we[0] = 1'b1; write_addr[0] = 5'd4; write_data[0] = 64'h77;
        busy_set = 1'b1; busy_addr = 5'd6;
        read_addr[1] = 5'd4;
        #1;
        n_checks++;
        if (read_data[1] !== 64'h77) begin
            n_fail++; $display("FAIL reset_bypass: got %h want 77", read_data[1]);
        end
        tick();
        rst = 1'b0;
        idle();
        #1;
        n_checks++;
        if (read_data[0] !== 64'd0 || read_data[1] !== 64'd0) begin
            n_fail++; $display("FAIL post_reset_x3_x4: got %h/%h want 0", read_data[0], read_data[1]);
        end
        read_addr[0] = 5'd5; read_addr[1] = 5'd7;
        #1;
        n_checks++;
        if (read_data[0] !== 64'd0 || read_data[1] !== 64'd0) begin
            n_fail++; $display("FAIL post_reset_x5_x7: got %h/%h want 0", read_data[0], read_data[1]);
        end
        n_checks++;
        if (busy_vec !== 32'd0 || read_busy !== 2'b00) begin
            n_fail++; $display("FAIL post_reset_busy: vec %h rb %b want 0", busy_vec, read_busy);
        end
    endtask

    initial begin
        rst       = 1'b1;
        read_addr = '0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        test_reset();
        test_bypass();
        test_conflict();
        test_x0();
        test_busy();
        test_set_clear_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_regfile_mp

`default_nettype wire
